// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c_top master between NREQ requesters.
// Each transaction is accepted, issued to the master, awaited and answered with a one-cycle response.
module i2c_req_arbiter #(
    parameter int NREQ      = 4,
    parameter int NEWD_HOLD = 5,
    parameter int TIMEOUT   = 4096,
    parameter int GW        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_op,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_din,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [7:0]          rsp_dout,
    output logic                rsp_ack_err,
    output logic                rsp_timeout,
    output logic [GW-1:0]       grant_id,
    output logic                arb_busy,
    output logic                m_newd,
    output logic                m_op,
    output logic [6:0]          m_addr,
    output logic [7:0]          m_din,
    input  logic [7:0]          m_dout,
    input  logic                m_busy,
    input  logic                m_ack_err,
    input  logic                m_done
);

    localparam int NPAD = 1 << GW;
    localparam int CMAX = (TIMEOUT > NEWD_HOLD) ? TIMEOUT : NEWD_HOLD;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(NEWD_HOLD - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [GW:0]   NREQ_W    = (GW+1)'(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_done_q;
    logic [GW-1:0]     r_last_grant;
    logic              w_complete;

    logic [NPAD-1:0]   w_valid_pad;
    logic [GW:0]       w_cand;
    logic              w_found;
    logic [GW-1:0]     w_sel;
    logic              w_sel_op;
    logic [6:0]        w_sel_addr;
    logic [7:0]        w_sel_din;
    logic [NREQ-1:0]   w_sel_oh;
    logic [NREQ-1:0]   w_grant_oh;

    logic [NREQ-1:0]   w_req_ready_nxt;
    logic [NREQ-1:0]   w_rsp_valid_nxt;
    logic [7:0]        w_rsp_dout_nxt;
    logic              w_rsp_ack_err_nxt;
    logic              w_rsp_timeout_nxt;
    logic [GW-1:0]     w_grant_nxt;
    logic              w_arb_busy_nxt;
    logic              w_m_newd_nxt;
    logic              w_m_op_nxt;
    logic [6:0]        w_m_addr_nxt;
    logic [7:0]        w_m_din_nxt;

    assign w_complete = m_done & ~r_done_q;

    // Scan from last_grant+1 upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        w_valid_pad = NPAD'(req_valid);
        w_found     = 1'b0;
        w_sel       = '0;
        w_cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, r_last_grant} + (GW+1)'(k);
            if (w_cand >= NREQ_W) begin
                w_cand = w_cand - NREQ_W;
            end
            if (!w_found && w_valid_pad[w_cand[GW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[GW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_op   = 1'b0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        w_sel_oh   = '0;
        w_grant_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_oh[i]   = (w_sel == GW'(i));
            w_grant_oh[i] = (grant_id == GW'(i));
            if (w_sel == GW'(i)) begin
                w_sel_op   = req_op[i];
                w_sel_addr = req_addr[7*i +: 7];
                w_sel_din  = req_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_done_q     <= 1'b0;
            r_last_grant <= GW'(NREQ - 1);
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_nxt;
            r_done_q <= m_done;
            if (r_state == S_RESP) begin
                r_last_grant <= grant_id;
            end
        end
    end

    // The shared counter times both the newd pulse and the WAIT timeout; it restarts at 0 on every state change.
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !m_busy) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_cnt == HOLD_LAST) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (w_complete || (r_cnt == TO_LAST)) begin
                    w_next_state = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_req_ready_nxt   = '0;
        w_rsp_valid_nxt   = '0;
        w_rsp_dout_nxt    = rsp_dout;
        w_rsp_ack_err_nxt = rsp_ack_err;
        w_rsp_timeout_nxt = rsp_timeout;
        w_grant_nxt       = grant_id;
        w_arb_busy_nxt    = (w_next_state != S_IDLE);
        w_m_newd_nxt      = (w_next_state == S_ISSUE);
        w_m_op_nxt        = m_op;
        w_m_addr_nxt      = m_addr;
        w_m_din_nxt       = m_din;
        if ((r_state == S_IDLE) && (w_next_state == S_ISSUE)) begin
            w_req_ready_nxt = w_sel_oh;
            w_grant_nxt     = w_sel;
            w_m_op_nxt      = w_sel_op;
            w_m_addr_nxt    = w_sel_addr;
            w_m_din_nxt     = w_sel_din;
        end
        // A done edge in the same cycle as expiry is reported as a normal completion.
        if ((r_state == S_WAIT) && (w_next_state == S_RESP)) begin
            w_rsp_valid_nxt = w_grant_oh;
            if (w_complete) begin
                w_rsp_dout_nxt    = m_op ? m_dout : 8'h00;
                w_rsp_ack_err_nxt = m_ack_err;
                w_rsp_timeout_nxt = 1'b0;
            end else begin
                w_rsp_dout_nxt    = 8'h00;
                w_rsp_ack_err_nxt = 1'b0;
                w_rsp_timeout_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_dout    <= '0;
            rsp_ack_err <= 1'b0;
            rsp_timeout <= 1'b0;
            grant_id    <= '0;
            arb_busy    <= 1'b0;
            m_newd      <= 1'b0;
            m_op        <= 1'b0;
            m_addr      <= '0;
            m_din       <= '0;
        end else begin
            req_ready   <= w_req_ready_nxt;
            rsp_valid   <= w_rsp_valid_nxt;
            rsp_dout    <= w_rsp_dout_nxt;
            rsp_ack_err <= w_rsp_ack_err_nxt;
            rsp_timeout <= w_rsp_timeout_nxt;
            grant_id    <= w_grant_nxt;
            arb_busy    <= w_arb_busy_nxt;
            m_newd      <= w_m_newd_nxt;
            m_op        <= w_m_op_nxt;
            m_addr      <= w_m_addr_nxt;
            m_din       <= w_m_din_nxt;
        end
    end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one i2c_top master between NREQ independent requesters.
- Accepts one transaction at a time from a requester over a valid/ready handshake.
- Drives the master's newd/op/addr/din pins, waits for completion, then returns dout and status to the granted requester as a one-cycle response.
- Sits directly in front of i2c_top; all master pins connect to the m_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NEWD_HOLD, 5, cycles m_newd is held high per transaction (>=1).
- TIMEOUT, 4096, max cycles in WAIT before the transaction is aborted with rsp_timeout.
- GW, 3, width of grant index, must satisfy 2^GW >= NREQ.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester transaction request.
- req_op  in  NREQ  per-requester op (0 = write, 1 = read).
- req_addr  in  7*NREQ  per-requester 7-bit slave address; requester i at bits [7i+6:7i].
- req_din  in  8*NREQ  per-requester write data; requester i at bits [8i+7:8i].
- req_ready  out  NREQ  one-hot one-cycle accept pulse.
- rsp_valid  out  NREQ  one-hot one-cycle response pulse.
- rsp_dout  out  8  read data; 0 for writes.
- rsp_ack_err  out  1  master reported ack error; valid with rsp_valid.
- rsp_timeout  out  1  transaction aborted by timeout; valid with rsp_valid.
- grant_id  out  GW  index of the current or last granted requester.
- arb_busy  out  1  high in every state except IDLE.
- m_newd  out  1  to master newd.
- m_op  out  1  to master op.
- m_addr  out  7  to master addr.
- m_din  out  8  to master din.
- m_dout  in  8  from master dout.
- m_busy  in  1  from master busy.
- m_ack_err  in  1  from master ack_err.
- m_done  in  1  from master done.

Behaviour:

Reset (async, rst=1):
- All outputs 0; state = IDLE.
- last_grant = NREQ-1, so requester 0 has first priority.
- All counters 0; done_q = 0.

All outputs are registered.

State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE:

IDLE:
- If any req_valid is high and m_busy=0, select the first valid requester scanning last_grant+1, last_grant+2, … modulo NREQ.
- Latch that requester's op/addr/din into m_op/m_addr/m_din.
- Set grant_id = g and go to ISSUE.
- If m_busy=1, stay in IDLE.

ISSUE:
- m_newd=1 for exactly NEWD_HOLD cycles; req_ready[g]=1 in the first ISSUE cycle only.
- Then m_newd=0 and go to WAIT.
- Requesters hold req_valid and their fields stable until req_ready is seen, and drop req_valid the cycle after. Fields are already latched, so later changes are ignored.

WAIT:
- done_q registers m_done every cycle; completion = m_done & ~done_q (rising edge).
- On completion: capture rsp_dout = (m_op ? m_dout : 0), rsp_ack_err = m_ack_err, rsp_timeout = 0; go to RESP.
- Wait counter starts at 0 on WAIT entry. When it reaches TIMEOUT-1 without completion, capture rsp_dout = 0, rsp_ack_err = 0, rsp_timeout = 1; go to RESP.
- If completion and expiry occur in the same cycle, completion wins.

RESP:
- rsp_valid[g]=1 for one cycle; rsp_* fields are held until the next RESP.
- last_grant = g; return to IDLE.

Further rules:
- m_done edges outside WAIT are ignored.
- Minimum latency from grant to rsp_valid is NEWD_HOLD+2 cycles.
- Fairness: a continuously requesting requester is served within NREQ transactions.
- rst mid-transaction aborts immediately: m_newd=0, no response is issued, and priority returns to requester 0.
- arb_busy = (state != IDLE).

Test Plan:
1. Single write: req 0 valid, op=0, addr=3, din=5. Expect req_ready[0] one cycle; m_newd high 5 cycles with m_addr=3, m_din=5; after a master done edge, rsp_valid[0] one cycle, rsp_ack_err=0, rsp_dout=0.
2. Single read: req 2, op=1, addr=4; master returns dout=0x2A. Expect rsp_valid[2] with rsp_dout=0x2A and grant_id=2.
3. Round-robin: req 0, 1 and 3 all held valid from reset. Expect grant order 0, 1, 3, 0, 1, 3; no requester served twice before the others.
4. Timeout: TIMEOUT=16, master never raises done. Expect rsp_valid with rsp_timeout=1, rsp_ack_err=0, exactly 16 cycles after WAIT entry; arbiter back in IDLE next cycle.
5. Ack error and busy gating: m_busy=1 holds the arbiter in IDLE with no m_newd. Then release m_busy, and the master completes with ack_err=1. Expect rsp_ack_err=1 and rsp_timeout=0.
6. Reset mid-WAIT: assert rst during WAIT. Expect all outputs 0 asynchronously, no rsp_valid, and after release requester 0 (valid, alongside 1) granted first.
